multiword_add_seq: RTL

- Multi-cycle sequencer that performs WIDTH-bit add/subtract by stepping one 16-bit limb per cycle through a 16-bit limb adder, rippling the carry between limbs in a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area; it is the controller that reuses the team's 16-bit prefix adder for wide operands.

---
 rtl/multiword_add_pkg.sv | 6 +
 rtl/limb_adder16.sv | 23 ++
 rtl/multiword_add_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/multiword_add_pkg.sv
// multiword_add_pkg: shared limb width, limb type and sequencer state encoding
package multiword_add_pkg;
  localparam int LIMB_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [15:0] limb_t;
endpackage

// File: rtl/limb_adder16.sv
// limb_adder16: combinational 16-bit Kogge-Stone prefix adder with carry-in
module limb_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p;
  // cin folds into bit-0 generate so every prefix G[i:0] already includes it
  always_comb begin
    g = a & b;
    p = a ^ b;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < 16; d = d * 2)
      for (int i = 15; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    sum = a ^ b ^ {g[14:0], cin};
    cout = g[15];
  end
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: WIDTH-bit add/sub, one 16-bit limb per cycle; MULTIWORD_ADD_SEQ_OVF_EN adds out_ovf
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy,
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  output logic             out_carry,
  output logic             out_ovf
`else
  output logic             out_carry
`endif
);
  localparam int NUM_LIMBS = WIDTH / LIMB_W;
  localparam int IW = NUM_LIMBS > 1 ? $clog2(NUM_LIMBS) : 1;
  state_e state, nxt;
  logic [IW-1:0] idx;
  limb_t [NUM_LIMBS-1:0] a_r, b_r, sum_r;
  limb_t bx, ls;
  logic sub_r, carry_r, lc, last;
  assign last = idx == IW'(NUM_LIMBS - 1);
  assign bx = b_r[idx] ^ {LIMB_W{sub_r}};
  assign out_sum = sum_r;
  limb_adder16 u_add (.a(a_r[idx]), .b(bx), .cin(carry_r), .sum(ls), .cout(lc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid ? RUN : IDLE;
      RUN: nxt = last ? DONE : RUN;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      sub_r <= 1'b0;
      carry_r <= 1'b0;
      sum_r <= '0;
      out_carry <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r <= in_a;
      b_r <= in_b;
      sub_r <= in_sub;
      carry_r <= in_sub;
      sum_r <= '0;
      idx <= '0;
      out_carry <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else if (state == RUN) begin
      sum_r[idx] <= ls;
      carry_r <= lc;
      idx <= last ? '0 : idx + IW'(1);
      if (last) begin
        out_carry <= lc;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        // carry into the MSB recovered from the MSB sum bit
        out_ovf <= ls[15] ^ a_r[idx][15] ^ bx[15] ^ lc;
`endif
      end
    end
endmodule
